// File: rtl/sobel_frame_sched.sv
// sobel_frame_sched: frame sequencer between the SPI pixel bridge and the Sobel core.
// Optional build macro SOBEL_BORDER_ZERO_EN zeroes emitted results on the frame border.
module sobel_frame_sched #(
    parameter int unsigned PX_BITS  = 24,
    parameter int unsigned IMG_W    = 8,
    parameter int unsigned IMG_H    = 8,
    parameter int unsigned PIPE_LAT = 5
) (
    input  logic               clk_i,
    input  logic               nreset_i,
    input  logic               clear_i,
    input  logic [PX_BITS-1:0] px_in_i,
    input  logic               px_in_rdy_i,
    output logic [PX_BITS-1:0] sobel_px_o,
    output logic               sobel_px_vld_o,
    input  logic [PX_BITS-1:0] sobel_px_i,
    input  logic               sobel_px_vld_i,
    output logic [PX_BITS-1:0] px_out_o,
    output logic               px_out_rdy_o,
    output logic               busy_o,
    output logic               frame_done_o,
    output logic               overflow_o
);

    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned CNT_W = $clog2(NPIX + 1);
    localparam int unsigned FL_W  = $clog2(PIPE_LAT + 1);
    localparam logic [CNT_W-1:0] NPIX_C = CNT_W'(NPIX);
    // A latency covering the whole frame never reaches RUN; FILL then ends on the pixel count.
    localparam logic [CNT_W-1:0] LAT_C  = (PIPE_LAT >= NPIX) ? NPIX_C : CNT_W'(PIPE_LAT);
    localparam logic [FL_W-1:0]  FL_C   = FL_W'(PIPE_LAT);

    typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   in_cnt;
    logic [CNT_W-1:0]   out_cnt;
    logic [FL_W-1:0]    flush_cnt;
    logic               accept;
    logic               drop_in;
    logic               take_res;
    logic               inject;
    logic [CNT_W-1:0]   in_cnt_nxt;
    logic [CNT_W-1:0]   out_cnt_nxt;
    logic [PX_BITS-1:0] out_val;

    assign accept      = px_in_rdy_i && (state == IDLE || state == FILL || state == RUN);
    assign drop_in     = px_in_rdy_i && (state == FLUSH || state == DONE);
    assign take_res    = sobel_px_vld_i && (state == RUN || state == FLUSH);
    assign inject      = (state == FLUSH) && (flush_cnt < FL_C);
    assign in_cnt_nxt  = in_cnt + CNT_W'(1);
    assign out_cnt_nxt = out_cnt + CNT_W'(1);

`ifdef SOBEL_BORDER_ZERO_EN
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic             on_border;

    assign on_border = (row_cnt == '0) || (row_cnt == ROW_LAST) ||
                       (col_cnt == '0) || (col_cnt == COL_LAST);
    assign out_val   = on_border ? '0 : sobel_px_i;
`else
    assign out_val   = sobel_px_i;
`endif

    // Sequencer, forwarding register, result register and status flags
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state          <= IDLE;
            in_cnt         <= '0;
            out_cnt        <= '0;
            flush_cnt      <= '0;
            sobel_px_o     <= '0;
            sobel_px_vld_o <= 1'b0;
            px_out_o       <= '0;
            px_out_rdy_o   <= 1'b0;
            busy_o         <= 1'b0;
            frame_done_o   <= 1'b0;
            overflow_o     <= 1'b0;
`ifdef SOBEL_BORDER_ZERO_EN
            col_cnt        <= '0;
            row_cnt        <= '0;
`endif
        end else if (clear_i) begin
            state          <= IDLE;
            in_cnt         <= '0;
            out_cnt        <= '0;
            flush_cnt      <= '0;
            sobel_px_o     <= '0;
            sobel_px_vld_o <= 1'b0;
            px_out_o       <= '0;
            px_out_rdy_o   <= 1'b0;
            busy_o         <= 1'b0;
            frame_done_o   <= 1'b0;
            overflow_o     <= 1'b0;
`ifdef SOBEL_BORDER_ZERO_EN
            col_cnt        <= '0;
            row_cnt        <= '0;
`endif
        end else begin
            sobel_px_vld_o <= 1'b0;
            px_out_rdy_o   <= 1'b0;
            frame_done_o   <= 1'b0;

            if (accept) begin
                sobel_px_o     <= px_in_i;
                sobel_px_vld_o <= 1'b1;
                in_cnt         <= in_cnt_nxt;
            end else if (inject) begin
                sobel_px_o     <= '0;
                sobel_px_vld_o <= 1'b1;
                flush_cnt      <= flush_cnt + FL_W'(1);
            end

            if (drop_in) begin
                overflow_o <= 1'b1;
            end

            if (take_res) begin
                px_out_o     <= out_val;
                px_out_rdy_o <= 1'b1;
                out_cnt      <= out_cnt_nxt;
`ifdef SOBEL_BORDER_ZERO_EN
                if (col_cnt == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + ROW_W'(1);
                end else begin
                    col_cnt <= col_cnt + COL_W'(1);
                end
`endif
            end

            // Transitions see the pixel/result of this cycle already counted
            case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= FILL;
                        busy_o <= 1'b1;
                    end
                end
                FILL: begin
                    if (accept && in_cnt_nxt == NPIX_C) begin
                        state <= FLUSH;
                    end else if (in_cnt >= LAT_C) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (accept && in_cnt_nxt == NPIX_C) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (take_res && out_cnt_nxt == NPIX_C) begin
                        state        <= DONE;
                        busy_o       <= 1'b0;
                        frame_done_o <= 1'b1;
                        in_cnt       <= '0;
                        out_cnt      <= '0;
                        flush_cnt    <= '0;
`ifdef SOBEL_BORDER_ZERO_EN
                        col_cnt      <= '0;
                        row_cnt      <= '0;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
